universal_register: RTL and testbench

Parametrised general-purpose datapath register: the single-width load registers generalised in width, with hold, load, clear, shift, rotate and count modes and registered carry/borrow and zero flags. Used wherever the datapath needs a counter, shifter or loadable register of arbitrary width, such as an address counter, a serial/parallel converter or a loop index. One operation is applied per enabled clock edge.

---
 rtl/universal_register.sv | 112 +++++++++++
 tb/tb_universal_register.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/universal_register.sv
// ============================================================================
// universal_register
//   General-purpose datapath register: hold, load, clear, shift, rotate and
//   count, with a registered carry/borrow/shift-out flag and a zero flag.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module universal_register #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] RST_VAL  = '0,
  parameter bit               SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in,
  input  logic             sin,
  output logic [WIDTH-1:0] out,
  output logic             co,
  output logic             zero
);

  localparam logic [2:0] OP_HOLD  = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_CLEAR = 3'b010;
  localparam logic [2:0] OP_SHL   = 3'b011;
  localparam logic [2:0] OP_SHR   = 3'b100;
  localparam logic [2:0] OP_INC   = 3'b101;
  localparam logic [2:0] OP_DEC   = 3'b110;
  localparam logic [2:0] OP_ROL   = 3'b111;

  localparam logic [WIDTH:0] C_ONE = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] out_nxt;
  logic             co_nxt;

  // Bit WIDTH of sum is the carry out; bit WIDTH of diff is the borrow.
  assign sum  = {1'b0, out} + C_ONE;
  assign diff = {1'b0, out} - C_ONE;

  always_comb begin
    out_nxt = out;
    co_nxt  = co;
    case (op)
      OP_HOLD: begin
        out_nxt = out;
        co_nxt  = co;
      end
      OP_LOAD: begin
        out_nxt = in;
        co_nxt  = 1'b0;
      end
      OP_CLEAR: begin
        out_nxt = '0;
        co_nxt  = 1'b0;
      end
      OP_SHL: begin
        out_nxt = {out[WIDTH-2:0], sin};
        co_nxt  = out[WIDTH-1];
      end
      OP_SHR: begin
        out_nxt = {sin, out[WIDTH-1:1]};
        co_nxt  = out[0];
      end
      OP_INC: begin
        if (SATURATE && sum[WIDTH]) begin
          out_nxt = out;
          co_nxt  = 1'b1;
        end else begin
          out_nxt = sum[WIDTH-1:0];
          co_nxt  = sum[WIDTH];
        end
      end
      OP_DEC: begin
        if (SATURATE && diff[WIDTH]) begin
          out_nxt = out;
          co_nxt  = 1'b1;
        end else begin
          out_nxt = diff[WIDTH-1:0];
          co_nxt  = diff[WIDTH];
        end
      end
      OP_ROL: begin
        out_nxt = {out[WIDTH-2:0], out[WIDTH-1]};
        co_nxt  = out[WIDTH-1];
      end
      default: begin
        out_nxt = out;
        co_nxt  = co;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out <= RST_VAL;
      co  <= 1'b0;
    end else if (en) begin
      out <= out_nxt;
      co  <= co_nxt;
    end
  end

  assign zero = (out == '0);

endmodule

`default_nettype wire

// File: tb/tb_universal_register.sv
// Testbench for universal_register: directed vector table plus randomized
// comparison against an arithmetic reference model for two widths.
`default_nettype none

module tb_universal_register;

  localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, CLR = 3'd2, SHL = 3'd3,
                         SHR = 3'd4, INC = 3'd5, DEC = 3'd6, ROL = 3'd7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // ---------------- 8-bit instances (wrap and saturate) ----------------
  logic       rst8 = 1'b1, en8 = 1'b0, sin8 = 1'b0;
  logic [2:0] op8 = HOLD;
  logic [7:0] in8 = 8'h00;
  logic [7:0] out8w, out8s;
  logic       co8w, co8s, zero8w, zero8s;

  universal_register #(.WIDTH(8), .RST_VAL(8'hA5), .SATURATE(1'b0)) dut8w (
    .clk(clk), .rst(rst8), .en(en8), .op(op8), .in(in8), .sin(sin8),
    .out(out8w), .co(co8w), .zero(zero8w));

  universal_register #(.WIDTH(8), .RST_VAL(8'hA5), .SATURATE(1'b1)) dut8s (
    .clk(clk), .rst(rst8), .en(en8), .op(op8), .in(in8), .sin(sin8),
    .out(out8s), .co(co8s), .zero(zero8s));

  // ---------------- random-test instances ----------------
  logic        rstr = 1'b1, enr = 1'b0, sinr = 1'b0;
  logic [2:0]  opr = HOLD;
  logic [4:0]  in5 = '0;
  logic [12:0] in13 = '0;
  logic [4:0]  out5;
  logic [12:0] out13;
  logic        co5, co13, zero5, zero13;

  universal_register #(.WIDTH(5), .RST_VAL(5'h0A), .SATURATE(1'b0)) dut5 (
    .clk(clk), .rst(rstr), .en(enr), .op(opr), .in(in5), .sin(sinr),
    .out(out5), .co(co5), .zero(zero5));

  universal_register #(.WIDTH(13), .RST_VAL(13'h1234), .SATURATE(1'b1)) dut13 (
    .clk(clk), .rst(rstr), .en(enr), .op(opr), .in(in13), .sin(sinr),
    .out(out13), .co(co13), .zero(zero13));

  task automatic chk(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: plain integer arithmetic on the register value.
  function automatic void ref_step(input int w, input bit sat, input int op,
                                   input longint din, input bit s,
                                   input longint m, input bit c,
                                   output longint mo, output bit co_o);
    longint full, top;
    full = longint'(1) << w;
    top  = full / 2;
    mo = m; co_o = c;
    case (op)
      0: begin mo = m; co_o = c; end
      1: begin mo = din; co_o = 0; end
      2: begin mo = 0; co_o = 0; end
      3: begin co_o = (m >= top); mo = (m * 2) % full + s; end
      4: begin co_o = bit'(m % 2); mo = m / 2 + (s ? top : 0); end
      5: begin
        if (m == full - 1) begin mo = sat ? m : 0; co_o = 1; end
        else begin mo = m + 1; co_o = 0; end
      end
      6: begin
        if (m == 0) begin mo = sat ? 0 : full - 1; co_o = 1; end
        else begin mo = m - 1; co_o = 0; end
      end
      default: begin co_o = (m >= top); mo = (m * 2) % full + m / top; end
    endcase
  endfunction

  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] op;
    logic [7:0] din;
    logic       sin;
    bit         sat;   // 1: check the saturating instance
    logic [7:0] eout;
    logic       eco;
  } vec_t;

  vec_t vecs[$];

  initial begin
    longint m5, m13, nm;
    bit     c5, c13, nc;

    // rst, en, op, in, sin, sat, expected out, expected co
    vecs.push_back('{1'b0, 1'b0, HOLD, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0});
    vecs.push_back('{1'b1, 1'b1, LOAD, 8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0});
    vecs.push_back('{1'b1, 1'b1, INC,  8'h00, 1'b0, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{1'b1, 1'b1, INC,  8'h00, 1'b0, 1'b0, 8'h01, 1'b0});
    vecs.push_back('{1'b1, 1'b1, LOAD, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0});
    vecs.push_back('{1'b1, 1'b1, DEC,  8'h00, 1'b0, 1'b1, 8'h00, 1'b1});
    vecs.push_back('{1'b1, 1'b1, LOAD, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{1'b1, 1'b1, DEC,  8'h00, 1'b0, 1'b0, 8'hFF, 1'b1});
    vecs.push_back('{1'b1, 1'b1, LOAD, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0});
    vecs.push_back('{1'b1, 1'b1, INC,  8'h00, 1'b0, 1'b1, 8'hFF, 1'b1});
    vecs.push_back('{1'b1, 1'b1, LOAD, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0});
    vecs.push_back('{1'b1, 1'b1, SHL,  8'h00, 1'b0, 1'b0, 8'h02, 1'b1});
    vecs.push_back('{1'b1, 1'b1, SHR,  8'h00, 1'b1, 1'b0, 8'h81, 1'b0});
    vecs.push_back('{1'b1, 1'b1, ROL,  8'h00, 1'b0, 1'b0, 8'h03, 1'b1});
    vecs.push_back('{1'b1, 1'b1, LOAD, 8'h10, 1'b0, 1'b0, 8'h10, 1'b0});
    vecs.push_back('{1'b1, 1'b0, INC,  8'h55, 1'b1, 1'b0, 8'h10, 1'b0});
    vecs.push_back('{1'b1, 1'b0, INC,  8'h55, 1'b1, 1'b0, 8'h10, 1'b0});
    vecs.push_back('{1'b1, 1'b0, INC,  8'h55, 1'b1, 1'b0, 8'h10, 1'b0});
    vecs.push_back('{1'b1, 1'b1, HOLD, 8'h55, 1'b1, 1'b0, 8'h10, 1'b0});
    vecs.push_back('{1'b1, 1'b1, LOAD, 8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0});
    vecs.push_back('{1'b1, 1'b1, INC,  8'h00, 1'b0, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{1'b1, 1'b1, HOLD, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{1'b1, 1'b0, CLR,  8'h00, 1'b0, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{1'b1, 1'b1, CLR,  8'h00, 1'b0, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{1'b1, 1'b1, SHR,  8'h00, 1'b1, 1'b0, 8'h80, 1'b0});

    foreach (vecs[i]) begin
      @(negedge clk);
      rst8 = vecs[i].rst; en8 = vecs[i].en; op8 = vecs[i].op;
      in8 = vecs[i].din; sin8 = vecs[i].sin;
      @(posedge clk); #1;
      if (vecs[i].sat) begin
        chk($sformatf("vec%0d_out_sat", i), out8s, vecs[i].eout);
        chk($sformatf("vec%0d_co_sat", i), co8s, vecs[i].eco);
        chk($sformatf("vec%0d_zero_sat", i), zero8s, vecs[i].eout == 8'h00);
      end else begin
        chk($sformatf("vec%0d_out", i), out8w, vecs[i].eout);
        chk($sformatf("vec%0d_co", i), co8w, vecs[i].eco);
        chk($sformatf("vec%0d_zero", i), zero8w, vecs[i].eout == 8'h00);
      end
    end

    // Asynchronous reset mid-cycle: visible before the next edge
    @(negedge clk);
    en8 = 1'b1; op8 = INC;
    @(posedge clk); #2;
    rst8 = 1'b0;
    #1;
    chk("async_rst_out", out8w, 8'hA5);
    chk("async_rst_co", co8w, 0);
    chk("async_rst_zero", zero8w, 0);
    // Held in reset across an enabled edge
    op8 = LOAD; in8 = 8'h77;
    @(posedge clk); #1;
    chk("rst_held_out", out8w, 8'hA5);
    // First op after release takes effect on the first edge with rst high
    @(negedge clk);
    rst8 = 1'b1;
    @(posedge clk); #1;
    chk("rst_release_out", out8w, 8'h77);
    chk("rst_release_co", co8w, 0);

    // ---------------- randomized run ----------------
    @(negedge clk);
    rstr = 1'b0;
    m5 = 5'h0A; c5 = 0; m13 = 13'h1234; c13 = 0;
    @(negedge clk);
    rstr = 1'b1;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      rstr = ($urandom_range(0, 63) != 0);
      enr  = ($urandom_range(0, 3) != 0);
      opr  = 3'($urandom_range(0, 7));
      sinr = 1'($urandom);
      in5  = 5'($urandom);
      in13 = 13'($urandom);
      if ($urandom_range(0, 7) == 0) in13 = '1;
      if ($urandom_range(0, 7) == 0) in5 = '1;
      #1;
      if (!rstr) begin
        m5 = 5'h0A; c5 = 0; m13 = 13'h1234; c13 = 0;
        chk("rnd_rst_out5", out5, m5);
        chk("rnd_rst_co13", co13, c13);
      end
      @(posedge clk);
      if (rstr && enr) begin
        ref_step(5, 1'b0, int'(opr), longint'(in5), sinr, m5, c5, nm, nc);
        m5 = nm; c5 = nc;
        ref_step(13, 1'b1, int'(opr), longint'(in13), sinr, m13, c13, nm, nc);
        m13 = nm; c13 = nc;
      end
      #1;
      chk("rnd_out5", out5, m5);
      chk("rnd_co5", co5, c5);
      chk("rnd_zero5", zero5, m5 == 0);
      chk("rnd_out13", out13, m13);
      chk("rnd_co13", co13, c13);
      chk("rnd_zero13", zero13, m13 == 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
